// File: rtl/lb_bankmux_pkg.sv
// Shared types and constants for the local-bus bank multiplexer.
package lb_bankmux_pkg;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    // Widest bank index the metadata struct can carry (up to 256 banks).
    localparam int unsigned BANK_IDX_MAXW = 8;

    function automatic int unsigned bank_idx_w(input int unsigned nbank);
        return (nbank <= 2) ? 1 : $clog2(nbank);
    endfunction

    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic [BANK_IDX_MAXW-1:0] bank;
        logic                     unmapped;
    } rd_meta_t;

endpackage

// File: rtl/lb_delayline.sv
// Fixed-depth shift register with synchronous reset; DEPTH of 0 is a wire.
module lb_delayline #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lb_bankmux.sv
// Local-bus to block-RAM bank multiplexer with a fixed READDELAY read latency.
module lb_bankmux
    import lb_bankmux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned NBANK      = 4,
    parameter int unsigned BANK_AW    = 12,
    parameter int unsigned BANK_LAT   = 2,
    parameter int unsigned READDELAY  = 5
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wren,
    input  logic [ADDR_WIDTH-1:0]       i_waddr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic                        i_rden,
    input  logic                        i_rdenlast,
    input  logic [ADDR_WIDTH-1:0]       i_raddr,
    output logic                        o_rvalid,
    output logic                        o_rvalidlast,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic [NBANK-1:0]            o_bank_we,
    output logic [BANK_AW-1:0]          o_bank_waddr,
    output logic [DATA_WIDTH-1:0]       o_bank_wdata,
    output logic [NBANK-1:0]            o_bank_re,
    output logic [BANK_AW-1:0]          o_bank_raddr,
    input  logic [NBANK*DATA_WIDTH-1:0] i_bank_rdata,
    output logic [7:0]                  o_err_cnt
);

    localparam int unsigned BW       = bank_idx_w(NBANK);
    localparam int unsigned MAP_W    = BANK_AW + BW;
    localparam int unsigned META_W   = $bits(rd_meta_t);
    localparam int unsigned META1_D  = BANK_LAT + 1;
    localparam int unsigned META2_D  = (READDELAY > BANK_LAT + 1) ? READDELAY - BANK_LAT - 1 : 1;
    localparam int unsigned DATA_DLY = (READDELAY >= BANK_LAT + 2) ? READDELAY - BANK_LAT - 2 : 0;
    localparam logic [DATA_WIDTH-1:0] UNMAP_W = DATA_WIDTH'(UNMAPPED_DATA);

    generate
        if (READDELAY < BANK_LAT + 2) begin : g_bad_delay
            $error("lb_bankmux: READDELAY must be at least BANK_LAT+2");
        end
    endgenerate

    logic [BW-1:0]    w_wr_bank;
    logic [BW-1:0]    w_rd_bank;
    logic             w_wr_unmapped;
    logic             w_rd_unmapped;
    logic [NBANK-1:0] w_wr_onehot;
    logic [NBANK-1:0] w_rd_onehot;

    assign w_wr_bank   = i_waddr[BANK_AW +: BW];
    assign w_rd_bank   = i_raddr[BANK_AW +: BW];
    assign w_wr_onehot = NBANK'(1) << w_wr_bank;
    assign w_rd_onehot = NBANK'(1) << w_rd_bank;

    generate
        if (MAP_W < ADDR_WIDTH) begin : g_unmap
            assign w_wr_unmapped = |i_waddr[ADDR_WIDTH-1:MAP_W];
            assign w_rd_unmapped = |i_raddr[ADDR_WIDTH-1:MAP_W];
        end else begin : g_all_mapped
            assign w_wr_unmapped = 1'b0;
            assign w_rd_unmapped = 1'b0;
        end
    endgenerate

    logic [NBANK-1:0]      r_bank_we;
    logic [BANK_AW-1:0]    r_bank_waddr;
    logic [DATA_WIDTH-1:0] r_bank_wdata;
    logic [NBANK-1:0]      r_bank_re;
    logic [BANK_AW-1:0]    r_bank_raddr;
    logic [7:0]            r_err_cnt;
    logic [DATA_WIDTH-1:0] r_cap;

    logic       w_wr_err;
    logic       w_rd_err;
    logic [8:0] w_err_sum;

    assign w_wr_err  = i_wren & w_wr_unmapped;
    assign w_rd_err  = i_rden & w_rd_unmapped;
    assign w_err_sum = {1'b0, r_err_cnt} + {8'd0, w_wr_err} + {8'd0, w_rd_err};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank_we    <= '0;
            r_bank_waddr <= '0;
            r_bank_wdata <= '0;
            r_bank_re    <= '0;
            r_bank_raddr <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_bank_we <= (i_wren && !w_wr_unmapped) ? w_wr_onehot : '0;
            r_bank_re <= (i_rden && !w_rd_unmapped) ? w_rd_onehot : '0;
            if (i_wren && !w_wr_unmapped) begin
                r_bank_waddr <= i_waddr[BANK_AW-1:0];
                r_bank_wdata <= i_wdata;
            end
            if (i_rden && !w_rd_unmapped) begin
                r_bank_raddr <= i_raddr[BANK_AW-1:0];
            end
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    // Read metadata is split so the capture stage can see it exactly when bank data lands.
    rd_meta_t w_meta_in;
    rd_meta_t w_meta1;
    rd_meta_t w_meta2;

    always_comb begin
        w_meta_in          = '0;
        w_meta_in.valid    = i_rden;
        w_meta_in.last     = i_rden & i_rdenlast;
        w_meta_in.bank     = BANK_IDX_MAXW'(w_rd_bank);
        w_meta_in.unmapped = i_rden & w_rd_unmapped;
    end

    lb_delayline #(
        .WIDTH (META_W),
        .DEPTH (META1_D)
    ) u_meta1 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (w_meta_in),
        .o_q     (w_meta1)
    );

    lb_delayline #(
        .WIDTH (META_W),
        .DEPTH (META2_D)
    ) u_meta2 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (w_meta1),
        .o_q     (w_meta2)
    );

    logic [DATA_WIDTH-1:0] w_bank_sel;
    assign w_bank_sel = i_bank_rdata[int'(w_meta1.bank[BW-1:0]) * DATA_WIDTH +: DATA_WIDTH];

    // Capture only on valid beats so the aligned stream, and thus rdata, holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cap <= '0;
        end else if (w_meta1.valid) begin
            r_cap <= w_meta1.unmapped ? UNMAP_W : w_bank_sel;
        end
    end

    logic [DATA_WIDTH-1:0] w_data_dly;

    lb_delayline #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DATA_DLY)
    ) u_data_dly (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (r_cap),
        .o_q     (w_data_dly)
    );

    logic w_unused;
    assign w_unused = ^{w_meta2.bank, w_meta2.unmapped, w_meta1.bank};

    assign o_rvalid     = w_meta2.valid;
    assign o_rvalidlast = w_meta2.last;
    assign o_rdata      = w_data_dly;
    assign o_bank_we    = r_bank_we;
    assign o_bank_waddr = r_bank_waddr;
    assign o_bank_wdata = r_bank_wdata;
    assign o_bank_re    = r_bank_re;
    assign o_bank_raddr = r_bank_raddr;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_lb_bankmux.sv
// Directed bench for lb_bankmux with a read-first, two-cycle bank memory model.
module tb_lb_bankmux;

    logic         clk = 1'b0;
    logic         reset;
    logic         wren;
    logic [23:0]  waddr;
    logic [31:0]  wdata;
    logic         rden;
    logic         rdenlast;
    logic [23:0]  raddr;
    logic         rvalid;
    logic         rvalidlast;
    logic [31:0]  rdata;
    logic [3:0]   bank_we;
    logic [11:0]  bank_waddr;
    logic [31:0]  bank_wdata;
    logic [3:0]   bank_re;
    logic [11:0]  bank_raddr;
    logic [127:0] bank_rdata;
    logic [7:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lb_bankmux u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_wren       (wren),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_rden       (rden),
        .i_rdenlast   (rdenlast),
        .i_raddr      (raddr),
        .o_rvalid     (rvalid),
        .o_rvalidlast (rvalidlast),
        .o_rdata      (rdata),
        .o_bank_we    (bank_we),
        .o_bank_waddr (bank_waddr),
        .o_bank_wdata (bank_wdata),
        .o_bank_re    (bank_re),
        .o_bank_raddr (bank_raddr),
        .i_bank_rdata (bank_rdata),
        .o_err_cnt    (err_cnt)
    );

    // Read-first banks, data valid two cycles after bank_re.
    logic [31:0] mem [4][4096];
    logic [31:0] p1 [4];
    logic [31:0] p2 [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_we[i]) mem[i][bank_waddr] <= bank_wdata;
            if (bank_re[i]) p1[i] <= mem[i][bank_raddr];
            p2[i] <= p1[i];
        end
    end

    assign bank_rdata = {p2[3], p2[2], p2[1], p2[0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; wren = 1'b0; waddr = '0; wdata = '0;
        rden = 1'b0; rdenlast = 1'b0; raddr = '0;
        for (int i = 0; i < 4; i++) begin
            p1[i] = '0;
            p2[i] = '0;
        end
        repeat (3) tick();
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rvalidlast", {31'd0, rvalidlast}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bank_we", {28'd0, bank_we}, 32'd0);
        check("rst_bank_re", {28'd0, bank_re}, 32'd0);
        check("rst_bank_waddr", {20'd0, bank_waddr}, 32'd0);
        check("rst_bank_wdata", bank_wdata, 32'd0);
        check("rst_bank_raddr", {20'd0, bank_raddr}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Single write to bank 2 offset 0x010, then read it back.
        wren = 1'b1; waddr = 24'h002010; wdata = 32'h12345678;
        tick();
        wren = 1'b0;
        check("wr_bank_we", {28'd0, bank_we}, 32'h4);
        check("wr_bank_waddr", {20'd0, bank_waddr}, 32'h010);
        check("wr_bank_wdata", bank_wdata, 32'h12345678);
        tick();
        check("wr_bank_we_clear", {28'd0, bank_we}, 32'h0);
        rden = 1'b1; raddr = 24'h002010;
        tick();
        rden = 1'b0;
        check("rd_bank_re", {28'd0, bank_re}, 32'h4);
        check("rd_bank_raddr", {20'd0, bank_raddr}, 32'h010);
        repeat (3) tick();
        check("rd_early_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check("rd_rdata", rdata, 32'h12345678);
        check("rd_rvalidlast", {31'd0, rvalidlast}, 32'd0);
        tick();
        check("rd_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("rd_rdata_hold", rdata, 32'h12345678);

        // Preload 16 words across banks 0..3, then burst-read them back to back.
        for (int b = 0; b < 16; b++) begin
            wren = 1'b1;
            waddr = {10'd0, 2'(b % 4), 12'(32'h20 + b)};
            wdata = 32'hB000_0000 + 32'(b) * 32'h111;
            tick();
        end
        wren = 1'b0;
        repeat (2) tick();
        for (int j = 0; j < 21; j++) begin
            if (j < 16) begin
                rden = 1'b1;
                rdenlast = (j == 15);
                raddr = {10'd0, 2'(j % 4), 12'(32'h20 + j)};
            end else begin
                rden = 1'b0;
                rdenlast = 1'b0;
            end
            tick();
            if (j >= 4 && j < 20) begin
                check("burst_rvalid", {31'd0, rvalid}, 32'd1);
                check("burst_rdata", rdata, 32'hB000_0000 + 32'(j - 4) * 32'h111);
                check("burst_rvalidlast", {31'd0, rvalidlast}, {31'd0, (j == 19)});
            end else begin
                check("burst_idle_rvalid", {31'd0, rvalid}, 32'd0);
            end
        end

        // rdenlast alone must be ignored.
        rdenlast = 1'b1;
        tick();
        rdenlast = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("lastonly_rvalid", {31'd0, rvalid}, 32'd0);
            check("lastonly_rvalidlast", {31'd0, rvalidlast}, 32'd0);
            tick();
        end

        // Unmapped read.
        rden = 1'b1; raddr = 24'h400000;
        tick();
        rden = 1'b0;
        check("unm_bank_re", {28'd0, bank_re}, 32'h0);
        repeat (3) tick();
        check("unm_early_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        check("unm_rvalid", {31'd0, rvalid}, 32'd1);
        check("unm_rdata", rdata, 32'hDEADBEEF);
        check("unm_err_cnt", {24'd0, err_cnt}, 32'd1);

        // Same-cycle write and read of bank 1 offset 5: read sees the old word.
        wren = 1'b1; waddr = 24'h001005; wdata = 32'hA;
        tick();
        wren = 1'b0;
        repeat (2) tick();
        wren = 1'b1; waddr = 24'h001005; wdata = 32'hB;
        rden = 1'b1; raddr = 24'h001005;
        tick();
        wren = 1'b0; rden = 1'b0;
        repeat (4) tick();
        check("rw_old_rvalid", {31'd0, rvalid}, 32'd1);
        check("rw_old_rdata", rdata, 32'hA);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        repeat (4) tick();
        check("rw_new_rvalid", {31'd0, rvalid}, 32'd1);
        check("rw_new_rdata", rdata, 32'hB);

        // Reset during beat 3 of an 8-beat burst.
        for (int j = 0; j < 3; j++) begin
            rden = 1'b1; raddr = {10'd0, 2'(j % 4), 12'(32'h20 + j)};
            tick();
        end
        reset = 1'b1;
        raddr = {10'd0, 2'd3, 12'h023};
        tick();
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        reset = 1'b0; rden = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
            tick();
        end
        check("post_rst_bank_re", {28'd0, bank_re}, 32'h0);
        check("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Unmapped write and read in one cycle count twice.
        wren = 1'b1; waddr = 24'h800000; wdata = 32'h5;
        rden = 1'b1; raddr = 24'h400000;
        tick();
        wren = 1'b0; rden = 1'b0;
        check("dual_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("dual_bank_we", {28'd0, bank_we}, 32'h0);

        // Saturation over 300 unmapped writes.
        wren = 1'b1; waddr = 24'hFF0000;
        repeat (100) tick();
        check("sat_mid_err_cnt", {24'd0, err_cnt}, 32'd102);
        repeat (200) tick();
        wren = 1'b0;
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
        tick();
        check("sat_hold_err_cnt", {24'd0, err_cnt}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lb_bankmux.md
# lb_bankmux

Local-bus bank multiplexer between a localbus read/write port and a set of NBANK block-RAM banks. It performs four jobs:
- decodes bus addresses into a bank select and an in-bank address;
- fans writes out to the selected bank;
- aligns bank read data to a fixed bus read latency (READDELAY);
- returns rvalid/rvalidlast in lockstep with rden/rdenlast.

It is the stage directly downstream of the localbus pin mapping and upstream of the memories, and it replaces per-bank read-latency handling.

## Interface
Parameters:
- DATA_WIDTH, 32, bus and bank data width
- ADDR_WIDTH, 24, bus address width
- NBANK, 4, number of banks (power of two, ≥2)
- BANK_AW, 12, in-bank address width
- BANK_LAT, 2, cycles from bank_re to bank_rdata valid
- READDELAY, 5, rden→rvalid latency; must be ≥ BANK_LAT+2 (elaboration error otherwise)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- wren  in  1  bus write strobe
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- rden  in  1  bus read strobe
- rdenlast  in  1  last read of a burst
- raddr  in  ADDR_WIDTH  read address
- rvalid  out  1  read data valid
- rvalidlast  out  1  marks the rdenlast beat
- rdata  out  DATA_WIDTH  read data
- bank_we  out  NBANK  one-hot bank write enable
- bank_waddr  out  BANK_AW  bank write address
- bank_wdata  out  DATA_WIDTH  bank write data
- bank_re  out  NBANK  one-hot bank read enable
- bank_raddr  out  BANK_AW  bank read address
- bank_rdata  in  NBANK*DATA_WIDTH  bank read data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
- err_cnt  out  8  saturating count of unmapped accesses

## Operation
- Address decode:
  - bank = addr[BANK_AW +: log2(NBANK)];
  - offset = addr[BANK_AW-1:0];
  - an address is unmapped if any bit at or above BANK_AW+log2(NBANK) is set.
- Write:
  - a mapped wren drives bank_we one-hot, bank_waddr and bank_wdata on the following cycle (registered);
  - an unmapped write is dropped and increments err_cnt.
- Read, mapped:
  - bank_re one-hot and bank_raddr are registered out the cycle after rden;
  - bank data is muxed by the pipelined bank index and then delayed to READDELAY.
- Read, unmapped:
  - no bank_re is issued;
  - rvalid still fires at READDELAY with rdata = 32'hDEAD_BEEF (UNMAPPED_DATA, truncated/zero-extended to DATA_WIDTH);
  - err_cnt increments.
- err_cnt:
  - saturates at 255;
  - an unmapped write and an unmapped read in the same cycle increment it by 2 (still saturating).
- Read metadata pipeline: {valid, last, bank, unmapped} travels in a shift register of depth READDELAY, so any rden pattern, including one per cycle, sustains full throughput.
- Simultaneous wren and rden:
  - both are issued in the same cycle with no ordering enforced;
  - banks are read-first, so a read of the address being written returns the old data.
- rdenlast without rden is ignored.
- No state machine: the block is a pure fixed-latency pipeline.

## Timing
- rden sampled at cycle t:
  - bank_re at t+1;
  - bank_rdata valid at t+1+BANK_LAT;
  - data captured at t+2+BANK_LAT;
  - rvalid/rvalidlast/rdata at t+READDELAY.
- wren sampled at t → bank_we at t+1.
- Reset values: rvalid, rvalidlast, bank_we, bank_re = 0; rdata, bank_waddr, bank_wdata, bank_raddr = 0; err_cnt = 0.
- Reset mid-burst:
  - all in-flight reads are discarded;
  - rvalid = 0 from the cycle after reset is sampled;
  - no stale rvalid may appear after reset deasserts.
- rdata holds its last value when rvalid = 0.

## Structure
- Package lb_bankmux_pkg holds:
  - UNMAPPED_DATA constant;
  - a bank-index width function (clog2 of NBANK);
  - the rd_meta_t struct {valid, last, bank, unmapped}.
- Sub-module lb_delayline: parameterised shift register (WIDTH, DEPTH) with synchronous reset. It is instantiated for the metadata path and for the data alignment path (depth READDELAY−BANK_LAT−2, with a pass-through when the depth is 0).

## Test plan
- Single write: wren to bank 2, offset 0x010, data 0x12345678 → bank_we = 4'b0100 at t+1, bank_waddr = 0x010; a later read returns 0x12345678 at exactly t+5.
- Burst read: 16 back-to-back reads across banks 0..3 with rdenlast on the final beat → 16 consecutive rvalid beats, correct per-bank data, rvalidlast only on beat 16.
- Unmapped read at addr 0x40_0000 → no bank_re; rvalid at t+5 with rdata 0xDEADBEEF; err_cnt = 1.
- Same-cycle write and read to bank 1, offset 5 (old value 0xA, new value 0xB) → read returns 0xA; a subsequent read returns 0xB.
- Reset asserted at cycle 3 of an 8-beat burst → rvalid = 0 from the next cycle; no rvalid after reset release; err_cnt = 0.
- 300 unmapped writes → err_cnt saturates at 255.
